// File: rtl/morph_window_3x3.sv
// morph_window_3x3: 3x3 grayscale morphology window stage (erode = min, dilate = max).
// It takes three vertically aligned row streams and emits one result for each interior
// pixel, together with that pixel's column index.
// Build option: define MORPH_SQUARE_KERNEL_EN to use the full 3x3 square kernel. When it
// is undefined the kernel is the 5-pixel cross. The port list is the same in both builds.
// Path from an accepted beat to the output: window register -> stage 1 partials -> stage 2 output.
module morph_window_3x3 #(
    parameter int DATA_W    = 8,
    parameter int PIC_WIDTH = 250,
    parameter int CW        = $clog2(PIC_WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              sync,
    input  logic              mode,
    input  logic [DATA_W-1:0] din1,
    input  logic [DATA_W-1:0] din2,
    input  logic [DATA_W-1:0] din3,
    output logic [DATA_W-1:0] dout,
    output logic              valid_out,
    output logic [CW-1:0]     col_out
);

    localparam logic [CW-1:0] LAST_COL = CW'(PIC_WIDTH - 1);

    // Two-input select: min when dil = 0, max when dil = 1 (unsigned compare).
    function automatic logic [DATA_W-1:0] pick2(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic              dil);
        if (dil) begin
            return (a > b) ? a : b;
        end else begin
            return (a < b) ? a : b;
        end
    endfunction

    // Three-input select, built from two 2-way selects.
    function automatic logic [DATA_W-1:0] pick3(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c,
                                               input logic              dil);
        return pick2(pick2(a, b, dil), c, dil);
    endfunction

    // Window indexed [row][column]: row 0 = din1 (above), column 0 = newest beat.
    logic [DATA_W-1:0] win_q [0:2][0:2];
    logic [CW-1:0]     col_q, col_d, beat_col_s;
    logic              row_mode_q, row_mode_d;
    logic              win_vld_q, win_vld_d;
    logic [CW-1:0]     win_col_q, win_col_d;
    logic              win_mode_q;
    logic [DATA_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
`ifdef MORPH_SQUARE_KERNEL_EN
    logic [DATA_W-1:0] s1_c_q, s1_c_d;
`endif
    logic              s1_vld_q, s1_mode_q;
    logic [CW-1:0]     s1_col_q;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_out_q;
    logic [CW-1:0]     col_out_q;

    // Column bookkeeping: resolve the current beat's column, the next counter value and the row mode.
    always_comb begin
        beat_col_s = col_q;
        col_d      = col_q;
        row_mode_d = row_mode_q;
        win_vld_d  = 1'b0;
        win_col_d  = beat_col_s - CW'(1);
        if (sync) begin
            beat_col_s = '0;
        end else begin
            beat_col_s = col_q;
        end
        win_col_d = beat_col_s - CW'(1);
        if (valid_in) begin
            if (beat_col_s == LAST_COL) begin
                col_d = '0;
            end else begin
                col_d = beat_col_s + CW'(1);
            end
            if (beat_col_s == '0) begin
                row_mode_d = mode;
            end else begin
                row_mode_d = row_mode_q;
            end
            win_vld_d = (beat_col_s >= CW'(2));
        end else if (sync) begin
            col_d = '0;
        end else begin
            col_d = col_q;
        end
    end

    // Stage 1 partial computation, taken from the completed window.
    always_comb begin
`ifdef MORPH_SQUARE_KERNEL_EN
        s1_a_d = pick3(win_q[0][0], win_q[1][0], win_q[2][0], win_mode_q);
        s1_b_d = pick3(win_q[0][1], win_q[1][1], win_q[2][1], win_mode_q);
        s1_c_d = pick3(win_q[0][2], win_q[1][2], win_q[2][2], win_mode_q);
`else
        s1_a_d = pick3(win_q[0][1], win_q[1][1], win_q[2][1], win_mode_q);
        s1_b_d = pick2(win_q[1][0], win_q[1][2], win_mode_q);
`endif
    end

    // Stage 2 final combine of the stage 1 partials.
    always_comb begin
`ifdef MORPH_SQUARE_KERNEL_EN
        dout_d = pick3(s1_a_q, s1_b_q, s1_c_q, s1_mode_q);
`else
        dout_d = pick2(s1_a_q, s1_b_q, s1_mode_q);
`endif
    end

    // Window shift, column counter and the window-complete tag (the tag carries its own column and mode).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            col_q      <= '0;
            row_mode_q <= 1'b0;
            win_vld_q  <= 1'b0;
            win_col_q  <= '0;
            win_mode_q <= 1'b0;
        end else begin
            if (valid_in) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][2] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][0];
                end
                win_q[0][0] <= din1;
                win_q[1][0] <= din2;
                win_q[2][0] <= din3;
            end
            col_q      <= col_d;
            row_mode_q <= row_mode_d;
            win_vld_q  <= win_vld_d;
            win_col_q  <= win_col_d;
            win_mode_q <= row_mode_q;
        end
    end

    // Pipeline stages 1 and 2. They advance every clock, so a bubble moves through as valid = 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_a_q      <= '0;
            s1_b_q      <= '0;
`ifdef MORPH_SQUARE_KERNEL_EN
            s1_c_q      <= '0;
`endif
            s1_vld_q    <= 1'b0;
            s1_col_q    <= '0;
            s1_mode_q   <= 1'b0;
            dout_q      <= '0;
            valid_out_q <= 1'b0;
            col_out_q   <= '0;
        end else begin
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
`ifdef MORPH_SQUARE_KERNEL_EN
            s1_c_q      <= s1_c_d;
`endif
            s1_vld_q    <= win_vld_q;
            s1_col_q    <= win_col_q;
            s1_mode_q   <= win_mode_q;
            valid_out_q <= s1_vld_q;
            if (s1_vld_q) begin
                dout_q    <= dout_d;
                col_out_q <= s1_col_q;
            end
        end
    end

    assign dout      = dout_q;
    assign valid_out = valid_out_q;
    assign col_out   = col_out_q;

endmodule
